// File: rtl/conv_job_arbiter.sv
// Round-robin job arbiter sharing one convolution engine between two requesters.
// Optional build macro: CONV_ARB_FIXED_PRIO_EN (r0 always wins when both request).
module conv_job_arbiter #(
    parameter int DATA_N   = 128,
    parameter int FILTER_N = 32,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_s_valid_x,
    output logic             r0_s_ready_x,
    input  logic [IN_W-1:0]  r0_s_data_in_x,
    input  logic             r0_s_valid_f,
    output logic             r0_s_ready_f,
    input  logic [IN_W-1:0]  r0_s_data_in_f,
    output logic             r0_m_valid_y,
    input  logic             r0_m_ready_y,
    output logic [OUT_W-1:0] r0_m_data_out_y,
    input  logic             r1_s_valid_x,
    output logic             r1_s_ready_x,
    input  logic [IN_W-1:0]  r1_s_data_in_x,
    input  logic             r1_s_valid_f,
    output logic             r1_s_ready_f,
    input  logic [IN_W-1:0]  r1_s_data_in_f,
    output logic             r1_m_valid_y,
    input  logic             r1_m_ready_y,
    output logic [OUT_W-1:0] r1_m_data_out_y,
    output logic             e_valid_x,
    input  logic             e_ready_x,
    output logic [IN_W-1:0]  e_data_x,
    output logic             e_valid_f,
    input  logic             e_ready_f,
    output logic [IN_W-1:0]  e_data_f,
    input  logic             e_valid_y,
    output logic             e_ready_y,
    input  logic [OUT_W-1:0] e_data_y,
    output logic             busy,
    output logic             grant,
    output logic             job_done
);

    localparam int CONV_N = DATA_N - FILTER_N + 1;
    localparam int XW = $clog2(DATA_N + 1);
    localparam int FW = $clog2(FILTER_N + 1);
    localparam int YW = $clog2(CONV_N + 1);
    localparam logic [XW-1:0] X_LIM  = XW'(DATA_N);
    localparam logic [FW-1:0] F_LIM  = FW'(FILTER_N);
    localparam logic [YW-1:0] Y_LIM  = YW'(CONV_N);
    localparam logic [YW-1:0] Y_LAST = YW'(CONV_N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic            grant_reg, grant_next;
    logic            last_reg, last_next;
    logic            job_done_reg, job_done_next;
    logic [XW-1:0]   x_cnt_reg, x_cnt_next;
    logic [FW-1:0]   f_cnt_reg, f_cnt_next;
    logic [YW-1:0]   y_cnt_reg, y_cnt_next;

    logic            s_valid_x [2];
    logic            s_valid_f [2];
    logic            m_ready_y [2];
    logic [IN_W-1:0] s_data_x  [2];
    logic [IN_W-1:0] s_data_f  [2];
    logic            sel       [2];
    logic            s_ready_x [2];
    logic            s_ready_f [2];
    logic            m_valid_y [2];
    logic [OUT_W-1:0] m_data_y [2];

    logic req0, req1, winner, x_open, f_open, x_hs, f_hs, y_hs;

    assign s_valid_x[0] = r0_s_valid_x;
    assign s_valid_x[1] = r1_s_valid_x;
    assign s_valid_f[0] = r0_s_valid_f;
    assign s_valid_f[1] = r1_s_valid_f;
    assign m_ready_y[0] = r0_m_ready_y;
    assign m_ready_y[1] = r1_m_ready_y;
    assign s_data_x[0]  = r0_s_data_in_x;
    assign s_data_x[1]  = r1_s_data_in_x;
    assign s_data_f[0]  = r0_s_data_in_f;
    assign s_data_f[1]  = r1_s_data_in_f;

    assign req0   = r0_s_valid_x | r0_s_valid_f;
    assign req1   = r1_s_valid_x | r1_s_valid_f;
    assign busy   = (state_reg == BUSY);
    assign grant  = grant_reg;
    assign job_done = job_done_reg;
    assign x_open = (x_cnt_reg < X_LIM);
    assign f_open = (f_cnt_reg < F_LIM);

`ifdef CONV_ARB_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    // On contention the requester that did not own the previous job wins.
    assign winner = (req0 & req1) ? ~last_reg : req1;
`endif

    // Engine-facing side: steered from the granted requester, silent while idle.
    assign e_valid_x = busy & s_valid_x[grant_reg] & x_open;
    assign e_valid_f = busy & s_valid_f[grant_reg] & f_open;
    assign e_data_x  = busy ? s_data_x[grant_reg] : '0;
    assign e_data_f  = busy ? s_data_f[grant_reg] : '0;
    assign e_ready_y = busy & m_ready_y[grant_reg];

    assign x_hs = e_valid_x & e_ready_x;
    assign f_hs = e_valid_f & e_ready_f;
    assign y_hs = busy & e_valid_y & m_ready_y[grant_reg];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign sel[gi]       = busy & (grant_reg == 1'(gi));
        assign s_ready_x[gi] = sel[gi] & e_ready_x & x_open;
        assign s_ready_f[gi] = sel[gi] & e_ready_f & f_open;
        assign m_valid_y[gi] = sel[gi] & e_valid_y;
        assign m_data_y[gi]  = sel[gi] ? e_data_y : '0;
    end

    assign r0_s_ready_x    = s_ready_x[0];
    assign r1_s_ready_x    = s_ready_x[1];
    assign r0_s_ready_f    = s_ready_f[0];
    assign r1_s_ready_f    = s_ready_f[1];
    assign r0_m_valid_y    = m_valid_y[0];
    assign r1_m_valid_y    = m_valid_y[1];
    assign r0_m_data_out_y = m_data_y[0];
    assign r1_m_data_out_y = m_data_y[1];

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        last_next     = last_reg;
        job_done_next = 1'b0;
        x_cnt_next    = x_cnt_reg;
        f_cnt_next    = f_cnt_reg;
        y_cnt_next    = y_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req0 | req1) begin
                    grant_next = winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (x_hs) x_cnt_next = x_cnt_reg + 1'b1;
                if (f_hs) f_cnt_next = f_cnt_reg + 1'b1;
                if (y_hs) begin
                    // Completion is driven by the result count alone.
                    if (y_cnt_reg == Y_LAST) begin
                        state_next    = IDLE;
                        last_next     = grant_reg;
                        job_done_next = 1'b1;
                        x_cnt_next    = '0;
                        f_cnt_next    = '0;
                        y_cnt_next    = '0;
                    end else if (y_cnt_reg < Y_LIM) begin
                        y_cnt_next = y_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            last_reg     <= 1'b1;
            job_done_reg <= 1'b0;
            x_cnt_reg    <= '0;
            f_cnt_reg    <= '0;
            y_cnt_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            last_reg     <= last_next;
            job_done_reg <= job_done_next;
            x_cnt_reg    <= x_cnt_next;
            f_cnt_reg    <= f_cnt_next;
            y_cnt_reg    <= y_cnt_next;
        end
    end

endmodule

// File: tb/tb_conv_job_arbiter.sv
// Directed bench for conv_job_arbiter; the bench plays both requesters and the engine.
module tb_conv_job_arbiter;

    localparam int DATA_N   = 128;
    localparam int FILTER_N = 32;
    localparam int CONV_N   = 97;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        r_s_valid_x [2];
    logic        r_s_ready_x [2];
    logic [7:0]  r_s_data_x  [2];
    logic        r_s_valid_f [2];
    logic        r_s_ready_f [2];
    logic [7:0]  r_s_data_f  [2];
    logic        r_m_valid_y [2];
    logic        r_m_ready_y [2];
    logic [20:0] r_m_data_y  [2];
    logic        e_valid_x, e_ready_x, e_valid_f, e_ready_f, e_valid_y, e_ready_y;
    logic [7:0]  e_data_x, e_data_f;
    logic [20:0] e_data_y;
    logic        busy, grant, job_done;

    int vectors = 0;
    int errors  = 0;
    int xo, fo, ys, cyc;
    logic last_m;

    conv_job_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_s_valid_x(r_s_valid_x[0]), .r0_s_ready_x(r_s_ready_x[0]), .r0_s_data_in_x(r_s_data_x[0]),
        .r0_s_valid_f(r_s_valid_f[0]), .r0_s_ready_f(r_s_ready_f[0]), .r0_s_data_in_f(r_s_data_f[0]),
        .r0_m_valid_y(r_m_valid_y[0]), .r0_m_ready_y(r_m_ready_y[0]), .r0_m_data_out_y(r_m_data_y[0]),
        .r1_s_valid_x(r_s_valid_x[1]), .r1_s_ready_x(r_s_ready_x[1]), .r1_s_data_in_x(r_s_data_x[1]),
        .r1_s_valid_f(r_s_valid_f[1]), .r1_s_ready_f(r_s_ready_f[1]), .r1_s_data_in_f(r_s_data_f[1]),
        .r1_m_valid_y(r_m_valid_y[1]), .r1_m_ready_y(r_m_ready_y[1]), .r1_m_data_out_y(r_m_data_y[1]),
        .e_valid_x(e_valid_x), .e_ready_x(e_ready_x), .e_data_x(e_data_x),
        .e_valid_f(e_valid_f), .e_ready_f(e_ready_f), .e_data_f(e_data_f),
        .e_valid_y(e_valid_y), .e_ready_y(e_ready_y), .e_data_y(e_data_y),
        .busy(busy), .grant(grant), .job_done(job_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            r_s_valid_x[i] = 1'b0; r_s_data_x[i] = '0;
            r_s_valid_f[i] = 1'b0; r_s_data_f[i] = '0;
            r_m_ready_y[i] = 1'b0;
        end
        e_ready_x = 1'b0; e_ready_f = 1'b0; e_valid_y = 1'b0; e_data_y = '0;
    endtask

    task automatic drive(input int id, input int x_total, input bit bp);
        r_s_valid_x[id] = (xo < x_total);
        r_s_data_x[id]  = 8'(xo);
        r_s_valid_f[id] = (fo < FILTER_N);
        r_s_data_f[id]  = 8'(fo + 100);
        e_ready_x       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        e_ready_f       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        e_valid_y       = (xo >= DATA_N) && (fo >= FILTER_N) && (ys < CONV_N);
        e_data_y        = 21'(ys * 7 - 300);
        r_m_ready_y[id] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Runs one job for requester id, starting at a falling edge with the DUT idle.
    task automatic run_job(input int id, input int x_total, input bit bp,
                           input int abort_at, input bit keep);
        int oth = 1 - id;
        bit first = 1'b1;
        xo = 0; fo = 0; ys = 0; cyc = 0;
        drive(id, x_total, bp);
        #1;
        check("idle_before_grant", {31'b0, busy}, 32'd0);
        while (ys < CONV_N) begin
            @(negedge clk);
            drive(id, x_total, bp);
            #1;
            if (first) begin
                check("job_done_low", {31'b0, job_done}, 32'd0);
                first = 1'b0;
            end
            check("busy_held", {31'b0, busy}, 32'd1);
            check("grant_id", {31'b0, grant}, 32'(id));
            check("other_quiet", {28'b0, r_s_ready_x[oth], r_s_ready_f[oth], r_m_valid_y[oth],
                                  |r_m_data_y[oth]}, 32'd0);
            if (r_s_valid_x[id] && xo >= DATA_N)
                check("x_sat", {30'b0, r_s_ready_x[id], e_valid_x}, 32'd0);
            if (e_valid_x && e_ready_x) begin
                check("e_data_x", {24'b0, e_data_x}, {24'b0, 8'(xo)});
                check("x_ready", {31'b0, r_s_ready_x[id]}, 32'd1);
            end
            if (e_valid_f && e_ready_f)
                check("e_data_f", {24'b0, e_data_f}, {24'b0, 8'(fo + 100)});
            if (r_s_valid_x[id] && r_s_ready_x[id]) xo++;
            if (r_s_valid_f[id] && r_s_ready_f[id]) fo++;
            if (e_valid_y && r_m_ready_y[id]) begin
                check("y_valid", {30'b0, r_m_valid_y[id], e_ready_y}, 32'd3);
                check("y_data", {11'b0, r_m_data_y[id]}, {11'b0, 21'(ys * 7 - 300)});
                ys++;
            end
            cyc++;
            if (abort_at > 0 && xo >= abort_at) return;
            if (cyc > 4000) begin
                check("job_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(negedge clk);
        e_valid_y = 1'b0;
        if (!keep) begin
            r_s_valid_x[id] = 1'b0;
            r_s_valid_f[id] = 1'b0;
        end
        #1;
        check("job_done_pulse", {30'b0, job_done, busy}, 32'd2);
        check("x_accepted", 32'(xo), 32'(DATA_N));
        last_m = id[0];
        $display("job r%0d: x=%0d f=%0d y=%0d cycles=%0d", id, xo, fo, ys, cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_m = 1'b1;
    endtask

    initial begin
        int exp_w;
        clear_inputs();
        last_m = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", {27'b0, busy, grant, job_done, e_valid_x, e_ready_y}, 32'd0);
        check("rst_readys", {28'b0, r_s_ready_x[0], r_s_ready_f[0], r_s_ready_x[1], r_m_valid_y[1]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // r0 alone, full job, no backpressure
        run_job(0, DATA_N, 1'b0, 0, 1'b0);

        // both request right after reset: r0 first, then r1 under backpressure
        do_reset();
        r_s_valid_x[1] = 1'b1; r_s_valid_f[1] = 1'b1;
        run_job(0, DATA_N, 1'b0, 0, 1'b0);
        run_job(1, DATA_N, 1'b1, 0, 1'b0);

        // over-supply of data samples
        run_job(0, 140, 1'b0, 0, 1'b0);

        // reset in the middle of an r1 job
        run_job(1, DATA_N, 1'b0, 50, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {29'b0, busy, grant, job_done}, 32'd0);
        check("mid_rst_hs", {28'b0, r_s_ready_x[1], e_valid_x, e_valid_f, e_ready_y}, 32'd0);
        check("mid_rst_data", {24'b0, e_data_x}, 32'd0);
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_m = 1'b1;
        r_s_valid_x[1] = 1'b1; r_s_valid_f[1] = 1'b1;
        run_job(0, DATA_N, 1'b0, 0, 1'b0);
        r_s_valid_x[1] = 1'b0; r_s_valid_f[1] = 1'b0;
        @(negedge clk);
        #1;
        check("idle_after", {31'b0, busy}, 32'd0);

        // both requesting continuously
        for (int j = 0; j < 3; j++) begin
`ifdef CONV_ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = last_m ? 0 : 1;
`endif
            for (int i = 0; i < 2; i++) begin
                r_s_valid_x[i] = 1'b1; r_s_valid_f[i] = 1'b1;
            end
            run_job(exp_w, DATA_N, 1'b0, 0, 1'b1);
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
